// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl: builds the 3x3 window for the G_x/G_y Sobel lanes from two
// line buffers, sums the squared lane results, thresholds them and queues them.
module sobel_window_ctrl #(
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 48,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_data,
    input  logic        in_sof,
    input  logic [28:0] thresh,
    output logic [71:0] gx_pos,
    output logic [71:0] gx_neg,
    output logic [71:0] gy_pos,
    output logic [71:0] gy_neg,
    input  logic [27:0] gx_sq,
    input  logic [27:0] gy_sq,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [28:0] out_mag,
    output logic        out_edge,
    output logic        out_eol,
    output logic        out_eof,
    output logic        frame_err,
    output logic        busy
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = CW + 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t                 state_q, state_d;
    logic [XW-1:0]          x_q, x_d;
    logic [YW-1:0]          y_q, y_d;
    logic [28:0]            thr_q, thr_d;
    logic [2:0][2:0][23:0]  win_q, win_d, win_nxt;
    logic [71:0]            gx_pos_q, gx_pos_d, gx_neg_q, gx_neg_d;
    logic [71:0]            gy_pos_q, gy_pos_d, gy_neg_q, gy_neg_d;
    logic                   frame_err_q, frame_err_d;
    logic [2:0]             vld_q, vld_d, eol_q, eol_d, eof_q, eof_d;
    logic [2:0][28:0]       pthr_q, pthr_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          mem_cnt_q, mem_cnt_d;
    logic                   out_valid_q, out_valid_d;
    logic [31:0]            out_ent_q, out_ent_d;

    logic [23:0]            lb_top [IMG_W];
    logic [23:0]            lb_mid [IMG_W];
    logic [31:0]            fifo_mem [FIFO_DEPTH];

    logic                   accept, take, win_ok, is_eol, is_last;
    logic [XW-1:0]          cur_x;
    logic [YW-1:0]          cur_y;
    logic [28:0]            thr_eff;
    logic [1:0]             inflight;
    logic [OW-1:0]          occ;
    logic [28:0]            mag;
    logic                   hit;
    logic [31:0]            push_ent;
    logic                   pop, load, mem_has, mem_rd, mem_wr;

    // Admission counts everything already committed downstream, since the lanes cannot stall.
    assign inflight = {1'b0, vld_q[0]} + {1'b0, vld_q[1]} + {1'b0, vld_q[2]};
    assign occ      = OW'(mem_cnt_q) + OW'(out_valid_q) + OW'(inflight);
    assign in_ready = reset & ((state_q == IDLE) |
                               ((state_q == RUN) & (occ < OW'(FIFO_DEPTH))));

    assign accept  = in_valid & in_ready;
    assign take    = accept & ((state_q == RUN) | in_sof);
    assign cur_x   = in_sof ? '0 : x_q;
    assign cur_y   = in_sof ? '0 : y_q;
    assign thr_eff = in_sof ? thresh : thr_q;
    assign win_ok  = (cur_x >= XW'(2)) & (cur_y >= YW'(2));
    assign is_eol  = (cur_x == X_LAST);
    assign is_last = is_eol & (cur_y == Y_LAST);

    assign mag      = {1'b0, gx_sq} + {1'b0, gy_sq};
    assign hit      = mag > pthr_q[2];
    assign push_ent = {mag, hit, eol_q[2], eof_q[2]};

    assign pop     = out_valid_q & out_ready;
    assign load    = ~out_valid_q | pop;
    assign mem_has = (mem_cnt_q != '0);
    assign mem_rd  = load & mem_has;
    assign mem_wr  = vld_q[2] & ~(load & ~mem_has);

    // Window after shifting one column left and inserting the new column on the right.
    always_comb begin
        win_nxt = win_q;
        for (int r = 0; r < 3; r++) begin
            win_nxt[r][0] = win_q[r][1];
            win_nxt[r][1] = win_q[r][2];
        end
        win_nxt[0][2] = lb_top[cur_x];
        win_nxt[1][2] = lb_mid[cur_x];
        win_nxt[2][2] = in_data;
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        thr_d       = thr_q;
        win_d       = win_q;
        gx_pos_d    = gx_pos_q;
        gx_neg_d    = gx_neg_q;
        gy_pos_d    = gy_pos_q;
        gy_neg_d    = gy_neg_q;
        frame_err_d = 1'b0;
        vld_d       = {vld_q[1:0], 1'b0};
        eol_d       = {eol_q[1:0], 1'b0};
        eof_d       = {eof_q[1:0], 1'b0};
        pthr_d      = {pthr_q[1:0], thr_q};

        if (take) begin
            win_d     = win_nxt;
            gx_pos_d  = {win_nxt[0][2], win_nxt[1][2], win_nxt[2][2]};
            gx_neg_d  = {win_nxt[0][0], win_nxt[1][0], win_nxt[2][0]};
            gy_pos_d  = {win_nxt[2][0], win_nxt[2][1], win_nxt[2][2]};
            gy_neg_d  = {win_nxt[0][0], win_nxt[0][1], win_nxt[0][2]};
            vld_d[0]  = win_ok;
            eol_d[0]  = is_eol;
            eof_d[0]  = is_last;
            pthr_d[0] = thr_eff;
            thr_d     = thr_eff;
            if (is_eol) begin
                x_d = '0;
                y_d = is_last ? '0 : YW'(cur_y + 1'b1);
            end else begin
                x_d = XW'(cur_x + 1'b1);
                y_d = cur_y;
            end
        end

        // A SOF while running restarts the frame; in-flight results keep their own flags.
        case (state_q)
            IDLE:    if (take) state_d = RUN;
            RUN: begin
                if (take & in_sof) frame_err_d = 1'b1;
                if (take & is_last) state_d = DRAIN;
            end
            DRAIN:   if (occ == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The output register always holds the oldest entry; the memory only backs it up.
    always_comb begin
        out_valid_d = out_valid_q;
        out_ent_d   = out_ent_q;
        wr_ptr_d    = mem_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = mem_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
        mem_cnt_d   = mem_cnt_q + CW'(mem_wr) - CW'(mem_rd);
        if (load) begin
            if (mem_has) begin
                out_valid_d = 1'b1;
                out_ent_d   = fifo_mem[rd_ptr_q];
            end else if (vld_q[2]) begin
                out_valid_d = 1'b1;
                out_ent_d   = push_ent;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            thr_q       <= '0;
            win_q       <= '0;
            gx_pos_q    <= '0;
            gx_neg_q    <= '0;
            gy_pos_q    <= '0;
            gy_neg_q    <= '0;
            frame_err_q <= 1'b0;
            vld_q       <= '0;
            eol_q       <= '0;
            eof_q       <= '0;
            pthr_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_ent_q   <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            thr_q       <= thr_d;
            win_q       <= win_d;
            gx_pos_q    <= gx_pos_d;
            gx_neg_q    <= gx_neg_d;
            gy_pos_q    <= gy_pos_d;
            gy_neg_q    <= gy_neg_d;
            frame_err_q <= frame_err_d;
            vld_q       <= vld_d;
            eol_q       <= eol_d;
            eof_q       <= eof_d;
            pthr_q      <= pthr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_cnt_q   <= mem_cnt_d;
            out_valid_q <= out_valid_d;
            out_ent_q   <= out_ent_d;
        end
    end

    // Line buffers cascade: the old y-1 entry becomes y-2 as the new pixel lands.
    always_ff @(posedge clk) begin
        if (take) begin
            lb_top[cur_x] <= lb_mid[cur_x];
            lb_mid[cur_x] <= in_data;
        end
        if (mem_wr) begin
            fifo_mem[wr_ptr_q] <= push_ent;
        end
    end

    assign gx_pos    = gx_pos_q;
    assign gx_neg    = gx_neg_q;
    assign gy_pos    = gy_pos_q;
    assign gy_neg    = gy_neg_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q == RUN) | (state_q == DRAIN);
    assign out_valid = out_valid_q;
    assign out_mag   = out_ent_q[31:3];
    assign out_edge  = out_ent_q[2];
    assign out_eol   = out_ent_q[1];
    assign out_eof   = out_ent_q[0];

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Randomized bench for sobel_window_ctrl: a frame-level Sobel model predicts every
// result, and a per-cycle monitor checks handshakes, flags, errors and ordering.
module tb_sobel_window_ctrl;

    localparam int IMG_W      = 8;
    localparam int IMG_H      = 6;
    localparam int FIFO_DEPTH = 4;
    localparam int M_IDLE     = 0;
    localparam int M_RUN      = 1;
    localparam int M_DRAIN    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_sof;
    logic [23:0] in_data;
    logic [28:0] thresh;
    logic [71:0] gx_pos, gx_neg, gy_pos, gy_neg;
    logic [27:0] gx_sq, gy_sq;
    logic        out_valid, out_ready, out_edge, out_eol, out_eof;
    logic [28:0] out_mag;
    logic        frame_err, busy;

    typedef struct {
        logic [28:0] mag;
        logic        isEdge;
        logic        eol;
        logic        eof;
        longint      avail;
    } resEntry;

    resEntry     expQ[$];
    logic [23:0] frame [IMG_H][IMG_W];
    int          mode = M_IDLE;
    int          mx = 0, my = 0;
    int          outstanding = 0;
    logic        errExp = 1'b0;
    logic [28:0] thrModel = '0;
    longint      cyc = 0;
    int          assertCount = 0, failCount = 0;
    int          eofCount = 0, framesDone = 0;
    int          readyMode = 0;
    logic [27:0] gxS1 = '0, gxS2 = '0, gyS1 = '0, gyS2 = '0;

    sobel_window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sof(in_sof), .thresh(thresh),
        .gx_pos(gx_pos), .gx_neg(gx_neg), .gy_pos(gy_pos), .gy_neg(gy_neg),
        .gx_sq(gx_sq), .gy_sq(gy_sq), .out_valid(out_valid), .out_ready(out_ready),
        .out_mag(out_mag), .out_edge(out_edge), .out_eol(out_eol), .out_eof(out_eof),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int lumaOf(input logic [23:0] p);
        int r, g, b;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
        return (77 * r + 150 * g + 29 * b) >> 4;
    endfunction

    function automatic logic [27:0] laneSq(input logic [71:0] pos, input logic [71:0] neg);
        int g;
        g = lumaOf(pos[71:48]) + 2 * lumaOf(pos[47:24]) + lumaOf(pos[23:0])
          - lumaOf(neg[71:48]) - 2 * lumaOf(neg[47:24]) - lumaOf(neg[23:0]);
        return 28'(g * g);
    endfunction

    // Stand-in for the two g_matrix lanes: fixed two-cycle latency.
    always @(posedge clk) begin
        gxS1 <= laneSq(gx_pos, gx_neg);
        gxS2 <= gxS1;
        gyS1 <= laneSq(gy_pos, gy_neg);
        gyS2 <= gyS1;
    end
    assign gx_sq = gxS2;
    assign gy_sq = gyS2;

    task automatic checkOutput(input string tag, input logic [71:0] observed, input logic [71:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Sobel gradients computed directly from the stored frame coordinates.
    task automatic modelPixel(input logic [23:0] d);
        int gx, gy, m;
        resEntry e;
        frame[my][mx] = d;
        if (mx >= 2 && my >= 2) begin
            gx = lumaOf(frame[my-2][mx]) + 2 * lumaOf(frame[my-1][mx]) + lumaOf(frame[my][mx])
               - lumaOf(frame[my-2][mx-2]) - 2 * lumaOf(frame[my-1][mx-2]) - lumaOf(frame[my][mx-2]);
            gy = lumaOf(frame[my][mx-2]) + 2 * lumaOf(frame[my][mx-1]) + lumaOf(frame[my][mx])
               - lumaOf(frame[my-2][mx-2]) - 2 * lumaOf(frame[my-2][mx-1]) - lumaOf(frame[my-2][mx]);
            m = gx * gx + gy * gy;
            e.mag    = 29'(m);
            e.isEdge = (29'(m) > thrModel);
            e.eol    = (mx == IMG_W - 1);
            e.eof    = (mx == IMG_W - 1) && (my == IMG_H - 1);
            e.avail  = cyc + 4;
            expQ.push_back(e);
            outstanding++;
        end
        if (mx == IMG_W - 1 && my == IMG_H - 1) mode = M_DRAIN;
        if (mx == IMG_W - 1) begin
            mx = 0;
            my++;
        end else begin
            mx++;
        end
    endtask

    // Per-cycle monitor: all checks happen mid-cycle, then the model steps past the edge.
    always @(negedge clk) begin : monitor
        int      outStart;
        logic    expReady;
        resEntry e;
        cyc++;
        if (reset) begin
            outStart = outstanding;
            expReady = (mode == M_IDLE) ? 1'b1 :
                       (mode == M_RUN)  ? (outstanding < FIFO_DEPTH) : 1'b0;
            checkOutput("inReady", in_ready, expReady);
            checkOutput("busy", busy, mode != M_IDLE);
            checkOutput("frameErr", frame_err, errExp);
            checkOutput("outValid", out_valid, (expQ.size() > 0) && (expQ[0].avail <= cyc));
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedResult", out_valid, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("outMag", out_mag, e.mag);
                    checkOutput("outEdge", out_edge, e.isEdge);
                    checkOutput("outEol", out_eol, e.eol);
                    checkOutput("outEof", out_eof, e.eof);
                    outstanding--;
                    if (e.eof) eofCount++;
                end
            end
            errExp = 1'b0;
            if (mode == M_DRAIN && outStart == 0) mode = M_IDLE;
            if (in_valid && in_ready) begin
                if (in_sof && (mode == M_IDLE || mode == M_RUN)) begin
                    if (mode == M_RUN) errExp = 1'b1;
                    thrModel = thresh;
                    mx = 0;
                    my = 0;
                    mode = M_RUN;
                    modelPixel(in_data);
                end else if (mode == M_RUN) begin
                    modelPixel(in_data);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        out_ready = (readyMode == 0) ? 1'b1 :
                    (readyMode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    task automatic sendPixel(input logic [23:0] d, input logic sof);
        int waitCycles;
        waitCycles = 0;
        in_data  = d;
        in_sof   = sof;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready || waitCycles >= 500) break;
            waitCycles++;
        end
        @(posedge clk);
        #1;
        if (waitCycles >= 500) checkOutput("acceptTimeout", waitCycles, 0);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    function automatic logic [23:0] pixelFor(input int kind, input int x, input int y);
        case (kind)
            0:       return 24'h808080;
            1:       return (x < IMG_W / 2) ? 24'h000000 : 24'hFFFFFF;
            2:       return (y < IMG_H / 2) ? 24'h000000 : 24'hFFFFFF;
            default: return 24'($urandom);
        endcase
    endfunction

    // One frame of the given pattern; optionally abort it with a SOF at pixel (2,3).
    task automatic applyStimulus(input int kind, input logic [28:0] thr, input bit inject);
        thresh = thr;
        if (inject) begin
            for (int p = 0; p < 3 * IMG_W + 2; p++)
                sendPixel(pixelFor(kind, p % IMG_W, p / IMG_W), p == 0);
        end
        for (int p = 0; p < IMG_W * IMG_H; p++)
            sendPixel(pixelFor(kind, p % IMG_W, p / IMG_W), p == 0);
        framesDone++;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) checkOutput("drainTimeout", busy, 0);
        checkOutput("pendingAfterDrain", expQ.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs();
        checkOutput("rstInReady", in_ready, 0);
        checkOutput("rstOutValid", out_valid, 0);
        checkOutput("rstOutMag", out_mag, 0);
        checkOutput("rstOutFlags", {out_edge, out_eol, out_eof}, 0);
        checkOutput("rstFrameErr", frame_err, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstGx", {gx_pos, gx_neg} != '0, 0);
        checkOutput("rstGy", {gy_pos, gy_neg} != '0, 0);
    endtask

    task automatic clearModel();
        expQ.delete();
        mode        = M_IDLE;
        outstanding = 0;
        errExp      = 1'b0;
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL globalTimeout: observed running, expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        thresh   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs();
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) sendPixel(24'($urandom), 1'b0);

        readyMode = 0;
        applyStimulus(0, 29'd0, 1'b0);
        waitIdle();
        applyStimulus(1, 29'd1000, 1'b0);
        waitIdle();
        applyStimulus(2, 29'd1000, 1'b0);
        waitIdle();

        readyMode = 1;
        applyStimulus(3, 29'($urandom_range(0, 200000000)), 1'b0);
        waitIdle();

        readyMode = 0;
        fork
            begin
                repeat (25) @(posedge clk);
                readyMode = 2;
                repeat (20) @(posedge clk);
                readyMode = 0;
            end
        join_none
        applyStimulus(3, 29'($urandom_range(0, 200000000)), 1'b0);
        waitIdle();

        readyMode = 1;
        applyStimulus(3, 29'($urandom_range(0, 200000000)), 1'b1);
        waitIdle();

        readyMode = 2;
        thresh = 29'd5000;
        for (int p = 0; p <= 2 * IMG_W + 4; p++)
            sendPixel(24'($urandom), p == 0);
        repeat (6) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checkResetOutputs();
        clearModel();
        readyMode = 0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(3, 29'($urandom_range(0, 200000000)), 1'b0);
        waitIdle();

        checkOutput("eofCount", eofCount, framesDone);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/sobel_window_ctrl.md
# sobel_window_ctrl

Streaming controller that sequences the two Sobel gradient lanes (G_x and G_y instances of `g_matrix`) over a raster RGB frame. It buffers two image lines, forms the 3x3 neighbourhood, and drives the six +/- pixel inputs of each lane. It tracks the lanes' fixed 2-cycle latency, sums G_x²+G_y², thresholds the result, and delivers magnitudes through a backpressure-safe result FIFO. It sits between the camera/pixel source and the edge-map sink.

## Interface
Parameters:
- `IMG_W`, 64, pixels per line (>=3)
- `IMG_H`, 48, lines per frame (>=3)
- `FIFO_DEPTH`, 8, result FIFO entries (power of two, >=4)

Ports:
- `clk`  input  1  single clock for the whole block
- `reset`  input  1  asynchronous, active-low reset
- `in_valid`  input  1  pixel valid
- `in_ready`  output  1  pixel accepted when `in_valid & in_ready`
- `in_data`  input  24  RGB888 pixel {R,G,B}
- `in_sof`  input  1  marks first pixel of frame
- `thresh`  input  29  edge threshold, sampled on accepted SOF pixel
- `gx_pos`  output  72  {p1a,p2,p1b} to G_x lane
- `gx_neg`  output  72  {m1a,m2,m1b} to G_x lane
- `gy_pos`, `gy_neg`  output  72 each  same packing for G_y lane
- `gx_sq`, `gy_sq`  input  28 each  lane `data_out`
- `out_valid`  output  1  result valid
- `out_ready`  input  1  result consumed when `out_valid & out_ready`
- `out_mag`  output  29  G_x²+G_y²
- `out_edge`  output  1  `out_mag > thresh` (strict)
- `out_eol`, `out_eof`  output  1 each  last result of row / of frame
- `frame_err`  output  1  one-cycle pulse: SOF received mid-frame
- `busy`  output  1  high in RUN or DRAIN

## Operation
- Window w[r][c]: r0 = top (line y-2), r2 = current line; c0 = left (col x-2), c2 = current column.
- G_x mapping: p1a=w[0][2], p2=w[1][2], p1b=w[2][2]; m1a=w[0][0], m2=w[1][0], m1b=w[2][0].
- G_y mapping: p1a=w[2][0], p2=w[2][1], p1b=w[2][2]; m1a=w[0][0], m2=w[0][1], m1b=w[0][2].
- Two line buffers, IMG_W x 24 each. At accepted pixel (x,y), read both at x (lines y-1, y-2), then write current pixel. Shift the window column left.
- Window is valid when x>=2 and y>=2. Only valid windows produce results, i.e. (IMG_W-2)(IMG_H-2) per frame. Border pixels produce none.
- FSM:
  - IDLE: `in_ready`=1. Non-SOF pixels are accepted and discarded. An accepted SOF pixel loads x=0,y=0, samples `thresh`, then goes to RUN.
  - RUN: x increments and wraps at IMG_W-1, then y increments. Accepting pixel (IMG_W-1, IMG_H-1) goes to DRAIN.
  - An accepted SOF pixel in RUN pulses `frame_err` and restarts the frame with that pixel as (0,0). The line buffers are not cleared. Results already in flight still deliver, with their flags unchanged.
  - DRAIN: `in_ready`=0. Go to IDLE when the in-flight pipe and the FIFO are both empty.
- Valid/flag shift register, 3 stages: window-drive, lane stage 1, lane stage 2. Flags carried: eol (x=IMG_W-1), eof (last pixel).
- At the stage-3 output, write {mag, edge, eol, eof} into the FIFO. mag = zero-extended gx_sq + gy_sq, 29 bits, no overflow possible.
- Flow control: `in_ready` (RUN) = (fifo_count + inflight) < FIFO_DEPTH. This guarantees the non-stallable lanes never overflow the FIFO.
- Reset values: `in_ready`=0 while reset is asserted, then IDLE. All other outputs = 0. FIFO, counters and valid pipe cleared. Reset mid-frame drops all in-flight results.

## Timing
- `gx_*`/`gy_*` are registered: they reflect the pixel accepted in cycle k during cycle k+1. They hold their value when no pixel is accepted.
- Lane results are sampled in cycle k+3. FIFO write happens at the end of cycle k+3.
- `out_valid` rises in cycle k+4 at the earliest, when the FIFO is empty. The FIFO output is registered.
- Sustained throughput is 1 result/cycle with `out_ready`=1.
- FIFO simultaneous read and write when full: allowed, count unchanged. Read while empty: ignored.
- `frame_err` is high for exactly the cycle after the offending accept.

## Test plan
- IMG_W=IMG_H=4, constant 0x808080 frame, `thresh`=0 -> 4 results with mag=0, edge=0; eol on results 2 and 4; eof on result 4; `busy` falls after the last result.
- 4x4 frame, columns 0-1 = 0x000000, columns 2-3 = 0xFFFFFF, `thresh`=1000 -> 4 results with mag=266342400 (G_x=16320, G_y=0) and edge=1.
- Same frame transposed (rows 0-1 black) -> mag=266342400 from G_y; G_x lane sees gx_pos==gx_neg (Y equal on both sides).
- 8x8 ramp, `out_ready` low for 20 cycles mid-frame -> `in_ready` falls within 1 cycle of fifo_count+inflight reaching 8. All 36 results arrive in order with no loss or duplicates.
- SOF injected at pixel (2,3) -> `frame_err` one-cycle pulse; the new frame completes with exactly 4 (4x4) results flagged eof on the last.
- `reset` asserted mid-frame with FIFO non-empty -> all outputs 0 immediately. After release: IDLE, `in_ready`=1, and a new frame yields correct results.
